// File: rtl/alu_axil_pkg.sv
// Shared types and constants for the AXI4-Lite ALU peripheral.
package alu_axil_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SRA = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_e;

  localparam logic [4:0] OFF_SRC_A  = 5'h00;
  localparam logic [4:0] OFF_SRC_B  = 5'h04;
  localparam logic [4:0] OFF_CTRL   = 5'h08;
  localparam logic [4:0] OFF_RESULT = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/alu_axil_slave_alu.sv
// Combinational 32-bit ALU using the core's 3-bit operation encoding.
module alu_axil_slave_alu
  import alu_axil_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLL: result_o = a_i << b_i[4:0];
      ALU_SRL: result_o = a_i >> b_i[4:0];
      ALU_SRA: result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_XOR: result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/alu_axil_slave.sv
// AXI4-Lite register front end for the ALU. Optional ALU_AXIL_IRQ_EN adds the irq
// output, a STATUS.IRQ_EN bit and W1C clearing of STATUS.DONE.
module alu_axil_slave
  import alu_axil_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int RESP_DLY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready
`ifdef ALU_AXIL_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [1:0] DLY = 2'(RESP_DLY);

  wr_state_e   w_state_q, w_state_d;
  rd_state_e   r_state_q, r_state_d;
  logic [1:0]  w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic        aw_held_q, w_held_q;
  logic [2:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [31:0] src_a_q, src_b_q, result_q;
  logic [2:0]  ctrl_q;
  logic        zero_q, done_q, calc_q;
  logic [31:0] alu_res;
  logic        alu_zero;

  logic        aw_fire, w_fire, ar_fire, commit, wr_ok;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data, rd_data, status_word;
  logic [3:0]  wr_strb;
  logic [1:0]  rd_resp;
  logic        ctrl_wr;

  logic unused_addr;
  assign unused_addr = ^{s_awaddr, s_araddr};

`ifdef ALU_AXIL_IRQ_EN
  logic irq_en_q, irq_q;
  assign status_word = {29'd0, irq_en_q, done_q, zero_q};
  assign irq         = irq_q;
`else
  assign status_word = {30'd0, done_q, zero_q};
`endif

  // AW and W may arrive in either order; the held copy wins once captured.
  assign aw_fire = s_awvalid & s_awready;
  assign w_fire  = s_wvalid & s_wready;
  assign wr_idx  = aw_held_q ? aw_idx_q : s_awaddr[4:2];
  assign wr_data = w_held_q ? w_data_q : s_wdata;
  assign wr_strb = w_held_q ? w_strb_q : s_wstrb;
  assign commit  = (w_state_q == W_IDLE) & (aw_held_q | aw_fire) & (w_held_q | w_fire);
  assign ctrl_wr = commit & (wr_idx == OFF_CTRL[4:2]) & wr_strb[0];

  always_comb begin
    wr_ok = 1'b0;
    case (wr_idx)
      OFF_SRC_A[4:2], OFF_SRC_B[4:2], OFF_CTRL[4:2]: wr_ok = 1'b1;
`ifdef ALU_AXIL_IRQ_EN
      OFF_STATUS[4:2]: wr_ok = 1'b1;
`endif
      default: wr_ok = 1'b0;
    endcase
  end

  // Write FSM: state register / next state / outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    case (w_state_q)
      W_IDLE: if (commit) begin
        w_state_d = W_RESP;
        w_cnt_d   = DLY;
      end
      W_RESP: begin
        if (w_cnt_q != 2'd0) w_cnt_d = w_cnt_q - 2'd1;
        else if (s_bready)   w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready = (w_state_q == W_IDLE) & ~aw_held_q;
    s_wready  = (w_state_q == W_IDLE) & ~w_held_q;
    s_bvalid  = (w_state_q == W_RESP) & (w_cnt_q == 2'd0);
    s_bresp   = bresp_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_fire) aw_idx_q <= s_awaddr[4:2];
      if (w_fire) begin
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_fire) aw_held_q <= 1'b1;
        if (w_fire)  w_held_q  <= 1'b1;
      end
    end
  end

  alu_axil_slave_alu u_alu (
    .a_i      (src_a_q),
    .b_i      (src_b_q),
    .op_i     (alu_op_e'(ctrl_q)),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  // Register file and one-cycle compute pipeline after a CTRL commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_a_q  <= '0;
      src_b_q  <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      calc_q   <= 1'b0;
`ifdef ALU_AXIL_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      calc_q <= ctrl_wr;
      if (commit && wr_idx == OFF_SRC_A[4:2]) src_a_q <= apply_strb(src_a_q, wr_data, wr_strb);
      if (commit && wr_idx == OFF_SRC_B[4:2]) src_b_q <= apply_strb(src_b_q, wr_data, wr_strb);
      if (ctrl_wr) begin
        ctrl_q <= wr_data[2:0];
        done_q <= 1'b0;
      end
`ifdef ALU_AXIL_IRQ_EN
      if (commit && wr_idx == OFF_STATUS[4:2] && wr_strb[0]) begin
        irq_en_q <= wr_data[2];
        if (wr_data[1]) done_q <= 1'b0;
      end
      irq_q <= done_q & irq_en_q;
`endif
      if (calc_q) begin
        result_q <= alu_res;
        zero_q   <= alu_zero;
        done_q   <= 1'b1;
      end
    end
  end

  assign ar_fire = s_arvalid & (r_state_q == R_IDLE);

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_araddr[4:2])
      OFF_SRC_A[4:2]:  rd_data = src_a_q;
      OFF_SRC_B[4:2]:  rd_data = src_b_q;
      OFF_CTRL[4:2]:   rd_data = {29'd0, ctrl_q};
      OFF_RESULT[4:2]: rd_data = result_q;
      OFF_STATUS[4:2]: rd_data = status_word;
      default:         rd_resp = RESP_SLVERR;
    endcase
  end

  // Read FSM: state register / next state / outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      if (ar_fire) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    case (r_state_q)
      R_IDLE: if (ar_fire) begin
        r_state_d = R_DATA;
        r_cnt_d   = DLY;
      end
      R_DATA: begin
        if (r_cnt_q != 2'd0) r_cnt_d = r_cnt_q - 2'd1;
        else if (s_rready)   r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready = (r_state_q == R_IDLE);
    s_rvalid  = (r_state_q == R_DATA) & (r_cnt_q == 2'd0);
    s_rdata   = rdata_q;
    s_rresp   = rresp_q;
  end

endmodule

// File: tb/tb_alu_axil_slave.sv
// Directed bench for alu_axil_slave: vector table plus handshake/reset sequences.
module tb_alu_axil_slave;
  import alu_axil_pkg::*;

  localparam int ADDR_W   = 5;
  localparam int RESP_DLY = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] s_awaddr = '0;
  logic              s_awvalid = 1'b0;
  logic              s_awready;
  logic [31:0]       s_wdata = '0;
  logic [3:0]        s_wstrb = '0;
  logic              s_wvalid = 1'b0;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready = 1'b0;
  logic [ADDR_W-1:0] s_araddr = '0;
  logic              s_arvalid = 1'b0;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready = 1'b0;
`ifdef ALU_AXIL_IRQ_EN
  logic              irq;
`endif

  alu_axil_slave #(.ADDR_W(ADDR_W), .RESP_DLY(RESP_DLY)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready)
`ifdef ALU_AXIL_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, aw_acc, w_acc;
    int n;
    aw_done = 1'b0;
    w_done  = 1'b0;
    resp    = 2'bxx;
    @(negedge clk);
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    s_bready = 1'b1;
    n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_acc = s_awvalid && s_awready;
      w_acc  = s_wvalid && s_wready;
      @(posedge clk);
      @(negedge clk);
      if (aw_acc) begin s_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_acc)  begin s_wvalid  = 1'b0; w_done  = 1'b1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      timeout("write addr/data");
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
      return;
    end
    n = 0;
    while (!s_bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_bvalid) timeout("write resp");
    else begin
      resp = s_bresp;
      @(posedge clk);
      @(negedge clk);
    end
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic ar_acc;
    int n;
    data = 'x;
    resp = 2'bxx;
    @(negedge clk);
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    while (s_arvalid && n < 50) begin
      ar_acc = s_arready;
      @(posedge clk);
      @(negedge clk);
      if (ar_acc) s_arvalid = 1'b0;
      n++;
    end
    if (s_arvalid) begin
      timeout("read addr");
      s_arvalid = 1'b0; s_rready = 1'b0;
      return;
    end
    n = 0;
    while (!s_rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_rvalid) timeout("read data");
    else begin
      data = s_rdata;
      resp = s_rresp;
      @(posedge clk);
      @(negedge clk);
    end
    s_rready = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t wv(input logic [4:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] r);
    vec_t v;
    v.is_wr = 1'b1; v.addr = a; v.data = d; v.strb = s; v.exp_data = '0; v.exp_resp = r;
    return v;
  endfunction

  function automatic vec_t rv(input logic [4:0] a, input logic [31:0] e, input logic [1:0] r);
    vec_t v;
    v.is_wr = 1'b0; v.addr = a; v.data = '0; v.strb = '0; v.exp_data = e; v.exp_resp = r;
    return v;
  endfunction

  localparam logic [1:0] OK = RESP_OKAY;
  localparam logic [1:0] SE = RESP_SLVERR;
`ifdef ALU_AXIL_IRQ_EN
  localparam logic [1:0] STATUS_WR_RESP = RESP_OKAY;
`else
  localparam logic [1:0] STATUS_WR_RESP = RESP_SLVERR;
`endif

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        seen_b, b_drop;
    int n;

    vecs.push_back(rv(5'h0C, 32'h0, OK));
    vecs.push_back(rv(5'h10, 32'h0, OK));
    vecs.push_back(wv(5'h00, 32'd5, 4'hF, OK));
    vecs.push_back(wv(5'h04, 32'd7, 4'hF, OK));
    vecs.push_back(wv(5'h08, 32'd0, 4'hF, OK));
    vecs.push_back(rv(5'h0C, 32'h0000000C, OK));
    vecs.push_back(rv(5'h10, 32'h2, OK));
    vecs.push_back(wv(5'h00, 32'd3, 4'hF, OK));
    vecs.push_back(wv(5'h04, 32'd3, 4'hF, OK));
    vecs.push_back(wv(5'h08, 32'd1, 4'hF, OK));
    vecs.push_back(rv(5'h0C, 32'h0, OK));
    vecs.push_back(rv(5'h10, 32'h3, OK));
    vecs.push_back(wv(5'h00, 32'h80000000, 4'hF, OK));
    vecs.push_back(wv(5'h04, 32'd4, 4'hF, OK));
    vecs.push_back(wv(5'h08, 32'd6, 4'hF, OK));
    vecs.push_back(rv(5'h0C, 32'hF8000000, OK));
    vecs.push_back(rv(5'h10, 32'h2, OK));
    vecs.push_back(rv(5'h08, 32'h6, OK));
    vecs.push_back(wv(5'h00, 32'hFF00FF00, 4'hF, OK));
    vecs.push_back(wv(5'h04, 32'h0F0F0F0F, 4'hF, OK));
    vecs.push_back(wv(5'h08, 32'd2, 4'hF, OK));
    vecs.push_back(rv(5'h0C, 32'h0F000F00, OK));
    vecs.push_back(wv(5'h08, 32'd3, 4'hF, OK));
    vecs.push_back(rv(5'h0C, 32'hFF0FFF0F, OK));
    vecs.push_back(wv(5'h08, 32'd7, 4'hF, OK));
    vecs.push_back(rv(5'h0C, 32'hF00FF00F, OK));
    vecs.push_back(wv(5'h08, 32'd4, 4'hF, OK));
    vecs.push_back(rv(5'h0C, 32'h7F800000, OK));
    vecs.push_back(wv(5'h08, 32'd5, 4'hF, OK));
    vecs.push_back(rv(5'h0C, 32'h0001FE01, OK));
    vecs.push_back(wv(5'h08, 32'd6, 4'hF, OK));
    vecs.push_back(rv(5'h0C, 32'hFFFFFE01, OK));
    vecs.push_back(wv(5'h08, 32'hFFFFFFFF, 4'hF, OK));
    vecs.push_back(rv(5'h08, 32'h7, OK));
    vecs.push_back(rv(5'h0C, 32'hF00FF00F, OK));
    vecs.push_back(wv(5'h00, 32'h11223344, 4'hF, OK));
    vecs.push_back(wv(5'h00, 32'hAABBCCDD, 4'h5, OK));
    vecs.push_back(rv(5'h00, 32'h11BB33DD, OK));
    vecs.push_back(wv(5'h04, 32'hDEADBEEF, 4'h0, OK));
    vecs.push_back(rv(5'h04, 32'h0F0F0F0F, OK));
    vecs.push_back(rv(5'h0C, 32'hF00FF00F, OK));
    vecs.push_back(wv(5'h0C, 32'h12345678, 4'hF, SE));
    vecs.push_back(rv(5'h0C, 32'hF00FF00F, OK));
    vecs.push_back(wv(5'h14, 32'h00000001, 4'hF, SE));
    vecs.push_back(rv(5'h18, 32'h0, SE));
    vecs.push_back(rv(5'h1C, 32'h0, SE));
    vecs.push_back(rv(5'h00, 32'h11BB33DD, OK));
    vecs.push_back(wv(5'h10, 32'h0, 4'hF, STATUS_WR_RESP));
    vecs.push_back(rv(5'h10, 32'h2, OK));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst awready", s_awready, 1);
    check("rst wready",  s_wready,  1);
    check("rst arready", s_arready, 1);
    check("rst bvalid",  s_bvalid,  0);
    check("rst rvalid",  s_rvalid,  0);
    check("rst bresp",   s_bresp,   0);
    check("rst rresp",   s_rresp,   0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
        check($sformatf("vec%0d bresp", i), rs, vecs[i].exp_resp);
      end else begin
        axi_read(vecs[i].addr, rd, rs);
        check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_data);
        check($sformatf("vec%0d rresp", i), rs, vecs[i].exp_resp);
      end
    end

    // W three cycles ahead of AW, then B held off for four cycles
    @(negedge clk);
    s_wdata = 32'h9; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
    check("seq1 wready idle", s_wready, 1);
    @(posedge clk);
    @(negedge clk);
    s_wvalid = 1'b0;
    check("seq1 wready held", s_wready, 0);
    check("seq1 awready held", s_awready, 1);
    repeat (2) @(negedge clk);
    s_awaddr = 5'h04; s_awvalid = 1'b1;
    check("seq1 awready before aw", s_awready, 1);
    @(posedge clk);
    @(negedge clk);
    s_awvalid = 1'b0;
    seen_b = 1'b0;
    b_drop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("seq1 awready low %0d", k), s_awready, 0);
      check($sformatf("seq1 wready low %0d", k), s_wready, 0);
      if (s_bvalid) seen_b = 1'b1;
      else if (seen_b) b_drop = 1'b1;
      if (k < 3) @(negedge clk);
    end
    check("seq1 bvalid up", s_bvalid, 1);
    check("seq1 bvalid stable", b_drop, 0);
    check("seq1 bresp", s_bresp, RESP_OKAY);
    s_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_bready = 1'b0;
    check("seq1 bvalid cleared", s_bvalid, 0);
    check("seq1 awready back", s_awready, 1);
    check("seq1 wready back", s_wready, 1);
    axi_read(5'h04, rd, rs);
    check("seq1 readback", rd, 32'h9);

    // Reset while a read response is pending
    @(negedge clk);
    s_araddr = 5'h00; s_arvalid = 1'b1; s_rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("seq2 rvalid pending", s_rvalid, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("seq2 rvalid dropped", s_rvalid, 0);
    check("seq2 arready", s_arready, 1);
    check("seq2 awready", s_awready, 1);
    for (int a = 0; a < 5; a++) begin
      axi_read(5'(a * 4), rd, rs);
      check($sformatf("seq2 reg%0d after reset", a), rd, 32'h0);
      check($sformatf("seq2 reg%0d resp", a), rs, RESP_OKAY);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_axil_slave.md
Name: alu_axil_slave

Overview:
- AXI4-Lite responder that exposes the core's 3-bit-opcode ALU as a memory-mapped compute peripheral.
- An AXI-Lite master writes operands and an opcode, then reads back the result and the zero/done flags.
- Sits on the AXI-Lite interconnect beside the simple RISC-V core and reuses the same ALU operation encoding.

Parameters:
- ADDR_W, 5, AXI address width; only addr[4:2] is decoded.
- RESP_DLY, 0, extra cycles (0..3) inserted before asserting BVALID/RVALID, for bench back-pressure coverage.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_awaddr  in  ADDR_W  write address
- s_awvalid / s_awready  in / out  1  write-address handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wvalid / s_wready  in / out  1  write-data handshake
- s_bresp  out  2  write response: 00 OKAY, 10 SLVERR
- s_bvalid / s_bready  out / in  1  write-response handshake
- s_araddr  in  ADDR_W  read address
- s_arvalid / s_arready  in / out  1  read-address handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out / in  1  read-data handshake

Behaviour:
- Register map (byte offsets):
  - 0x00 SRC_A, RW.
  - 0x04 SRC_B, RW.
  - 0x08 CTRL, RW; bits [2:0] op, other bits read 0.
  - 0x0C RESULT, RO.
  - 0x10 STATUS, RO; bit0 ZERO, bit1 DONE.
  - 0x14..0x1C unmapped.
- Reset values:
  - All registers, bresp and rresp are 0.
  - All VALID outputs are 0; awready, wready and arready are 1.
- Op encoding:
  - 000 add, 001 sub, 010 and, 011 or.
  - 100 sll and 101 srl, shift amount SRC_B[4:0].
  - 110 sra (signed arithmetic shift), 111 xor.
  - All arithmetic is 32-bit modulo; no carry or overflow flag.
- Write channel FSM, states W_IDLE, W_RESP:
  - AW and W are captured independently, in either order or in the same cycle.
  - awready drops once an address is held; wready drops once data is held.
  - When both are held, the register write commits and the FSM enters W_RESP.
  - BVALID asserts RESP_DLY cycles after commit and holds until bready.
  - awready and wready return to 1 in the cycle after the B handshake.
- Strobes: each wstrb bit enables its byte lane. wstrb = 0 is a legal no-op write with an OKAY response.
- Write errors:
  - A write to RESULT, STATUS or an unmapped address returns SLVERR and changes no state.
- Compute:
  - A committed write to CTRL clears DONE in the commit cycle.
  - On the next clock edge, RESULT = f(SRC_A, SRC_B, op), ZERO = (RESULT == 0) and DONE = 1.
  - Latency from CTRL commit to DONE is exactly 1 cycle.
  - Operand writes do not recompute; RESULT changes only after a CTRL write.
- Read channel FSM, states R_IDLE, R_DATA:
  - arready = 1 only in R_IDLE.
  - On the AR handshake, rdata and rresp are latched and RVALID asserts RESP_DLY cycles later.
  - RVALID, rdata and rresp hold stable until rready.
  - Reading an unmapped address returns rdata 0 with SLVERR.
- Simultaneous events:
  - Read and write in the same cycle proceed independently.
  - A read of RESULT or STATUS latched in the CTRL-commit cycle returns the pre-update value.
  - A read of SRC_A latched in the cycle SRC_A commits returns the old value.
- Reset mid-transaction: both FSMs return to idle and in-flight responses are dropped.

Optional Feature:
- Macro: ALU_AXIL_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and STATUS bit2 IRQ_EN (RW).
  - irq = DONE & IRQ_EN, registered and reset to 0.
  - Writing 1 to STATUS bit1 clears DONE (W1C).
  - STATUS writes of bits 1 and 2 return OKAY.
- Undefined:
  - No irq port; STATUS is fully RO and writes to it return SLVERR.

Decomposition:
- Package alu_axil_pkg holds:
  - the alu_op_e enum (ALU_ADD .. ALU_XOR, 3 bits);
  - register offset localparams (OFF_SRC_A .. OFF_STATUS);
  - RESP_OKAY and RESP_SLVERR;
  - the state enums for the write and read FSMs.
- One sub-module: instantiate the existing combinational alu for the datapath.
  - Its result and zero flag are registered in this block on the cycle after the CTRL commit.

Test Plan:
- Write SRC_A = 5, SRC_B = 7, CTRL = 000, then read RESULT -> 0x0000000C; STATUS -> 0x2 (DONE = 1, ZERO = 0).
- Write SRC_A = 3, SRC_B = 3, CTRL = 001 -> RESULT 0, STATUS 0x3; SRC_A = 0x80000000, SRC_B = 4, op 110 -> RESULT 0xF8000000.
- W presented 3 cycles before AW, with bready held low 4 cycles -> single BVALID held stable, bresp OKAY, awready and wready low until the B handshake.
- SRC_A = 0x11223344 then write 0xAABBCCDD with wstrb = 0101 -> readback 0x11BB33DD.
- Write to 0x0C -> bresp SLVERR and RESULT unchanged; read 0x18 -> rdata 0, rresp SLVERR.
- Assert reset while RVALID is pending -> RVALID 0 and arready 1 after release, and all registers read 0.
